// File: rtl/systolic_2x2.sv
// 2x2 output-stationary systolic matrix multiplier with 64-bit accumulators and sticky overflow flags.
// Optional macro SYSTOLIC_DONE_EN adds a done pulse and restarts accumulation every four steps.
module systolic_2x2 #(
    parameter logic [2:0] DATA_TYPE = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_in,
    input  logic [31:0] mat1_row0,
    input  logic [31:0] mat1_row1,
    input  logic [31:0] mat2_col0,
    input  logic [31:0] mat2_col1,
    output logic [63:0] result_row00,
    output logic [63:0] result_row01,
    output logic [63:0] result_row10,
    output logic [63:0] result_row11,
    output logic        carry_00,
    output logic        carry_01,
    output logic        carry_10,
    output logic        carry_11
`ifdef SYSTOLIC_DONE_EN
    ,
    output logic        done
`endif
);

    localparam bit IS_SIGNED = (DATA_TYPE == 3'b001) || (DATA_TYPE == 3'b100);

    typedef struct packed {
        logic [63:0] sum;
        logic        ovf;
    } mac_t;

    // Widen one operand word to 64 bits according to the configured element format.
    function automatic logic [63:0] widen(input logic [31:0] w);
        logic [63:0] r;
        case (DATA_TYPE)
            3'b000:  r = {56'b0, w[7:0]};
            3'b001:  r = {{56{w[7]}}, w[7:0]};
            3'b010:  r = {48'b0, w[15:0]};
            3'b100:  r = {{32{w[31]}}, w};
            default: r = {32'b0, w};
        endcase
        return r;
    endfunction

    function automatic mac_t mac(input logic [63:0] acc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        logic [64:0] wide;
        mac_t        r;
        prod  = widen(a) * widen(b);
        wide  = {1'b0, acc} + {1'b0, prod};
        r.sum = wide[63:0];
        if (IS_SIGNED)
            r.ovf = (acc[63] == prod[63]) && (wide[63] != acc[63]);
        else
            r.ovf = wide[64];
        return r;
    endfunction

    logic        load_in_q;
    logic        step;
    logic        restart;
    logic [31:0] a_f00, b_f00, b_f01, a_f10;
    mac_t        m00, m01, m10, m11;

    assign step = load_in & ~load_in_q;

`ifdef SYSTOLIC_DONE_EN
    logic [1:0] step_cnt;
    logic       restart_q;

    assign restart = restart_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= 2'd0;
            restart_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= step && (step_cnt == 2'd3);
            if (step) begin
                step_cnt  <= step_cnt + 2'd1;
                restart_q <= (step_cnt == 2'd3);
            end
        end
    end
`else
    assign restart = 1'b0;
`endif

    // A restarting step treats the old accumulator as zero, so the new sum is just the product.
    always_comb begin
        m00 = mac(restart ? 64'd0 : result_row00, mat1_row0, mat2_col0);
        m01 = mac(restart ? 64'd0 : result_row01, a_f00,     mat2_col1);
        m10 = mac(restart ? 64'd0 : result_row10, mat1_row1, b_f00);
        m11 = mac(restart ? 64'd0 : result_row11, a_f10,     b_f01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_in_q    <= 1'b0;
            a_f00        <= '0;
            b_f00        <= '0;
            b_f01        <= '0;
            a_f10        <= '0;
            result_row00 <= '0;
            result_row01 <= '0;
            result_row10 <= '0;
            result_row11 <= '0;
            carry_00     <= 1'b0;
            carry_01     <= 1'b0;
            carry_10     <= 1'b0;
            carry_11     <= 1'b0;
        end else begin
            load_in_q <= load_in;
            if (step) begin
                // NOTE: non-blocking updates let every PE read the pre-edge forwarding registers.
                a_f00        <= mat1_row0;
                b_f00        <= mat2_col0;
                b_f01        <= mat2_col1;
                a_f10        <= mat1_row1;
                result_row00 <= m00.sum;
                result_row01 <= m01.sum;
                result_row10 <= m10.sum;
                result_row11 <= m11.sum;
                carry_00     <= (carry_00 & ~restart) | m00.ovf;
                carry_01     <= (carry_01 & ~restart) | m01.ovf;
                carry_10     <= (carry_10 & ~restart) | m10.ovf;
                carry_11     <= (carry_11 & ~restart) | m11.ovf;
            end
        end
    end

endmodule

// File: tb/tb_systolic_2x2.sv
// Directed, table-driven bench for systolic_2x2 (uint32 instance plus an int8 instance on shared inputs).
module tb_systolic_2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_in;
    logic [31:0] mat1_row0, mat1_row1, mat2_col0, mat2_col1;
    logic [63:0] r00, r01, r10, r11;
    logic        c00, c01, c10, c11;
    logic [63:0] s00, s01, s10, s11;
    logic        sc00, sc01, sc10, sc11;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_2x2 #(.DATA_TYPE(3'b011)) dut (
        .clk(clk), .rst(rst), .load_in(load_in),
        .mat1_row0(mat1_row0), .mat1_row1(mat1_row1),
        .mat2_col0(mat2_col0), .mat2_col1(mat2_col1),
        .result_row00(r00), .result_row01(r01), .result_row10(r10), .result_row11(r11),
        .carry_00(c00), .carry_01(c01), .carry_10(c10), .carry_11(c11)
    );

    systolic_2x2 #(.DATA_TYPE(3'b001)) dut_s (
        .clk(clk), .rst(rst), .load_in(load_in),
        .mat1_row0(mat1_row0), .mat1_row1(mat1_row1),
        .mat2_col0(mat2_col0), .mat2_col1(mat2_col1),
        .result_row00(s00), .result_row01(s01), .result_row10(s10), .result_row11(s11),
        .carry_00(sc00), .carry_01(sc01), .carry_10(sc10), .carry_11(sc11)
    );

    typedef struct {
        logic [31:0] row0, row1, col0, col1;
        logic [63:0] e00, e01, e10, e11;
    } vec_t;

    vec_t func_tbl [4];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_carries(input string name, input logic [3:0] expected);
        check(name, {60'b0, c00, c01, c10, c11}, {60'b0, expected});
    endtask

    // Present operands, raise load_in for 'hold' cycles, then leave a gap before sampling.
    task automatic do_step(input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] cl0, input logic [31:0] cl1, input int hold);
        @(posedge clk); #1;
        mat1_row0 = r0; mat1_row1 = r1; mat2_col0 = cl0; mat2_col1 = cl1;
        load_in = 1'b1;
        repeat (hold) @(posedge clk);
        #1 load_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (cycles) begin
            mat1_row0 = $urandom; mat1_row1 = $urandom;
            mat2_col0 = $urandom; mat2_col1 = $urandom;
            load_in   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        load_in = 1'b0;
        mat1_row0 = '0; mat1_row1 = '0; mat2_col0 = '0; mat2_col1 = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_table(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            do_step(func_tbl[i].row0, func_tbl[i].row1, func_tbl[i].col0, func_tbl[i].col1, 2);
            check($sformatf("%s step%0d c00", tag, i + 1), r00, func_tbl[i].e00);
            check($sformatf("%s step%0d c01", tag, i + 1), r01, func_tbl[i].e01);
            check($sformatf("%s step%0d c10", tag, i + 1), r10, func_tbl[i].e10);
            check($sformatf("%s step%0d c11", tag, i + 1), r11, func_tbl[i].e11);
        end
    endtask

    initial begin
        // A = [[4,2],[1,8]], B = [[8,1],[2,4]] -> C = [[36,12],[24,33]]
        func_tbl[0] = '{row0: 4, row1: 0, col0: 8, col1: 0, e00: 32, e01: 0,  e10: 0,  e11: 0};
        func_tbl[1] = '{row0: 2, row1: 1, col0: 2, col1: 1, e00: 36, e01: 4,  e10: 8,  e11: 0};
        func_tbl[2] = '{row0: 0, row1: 8, col0: 0, col1: 4, e00: 36, e01: 12, e10: 24, e11: 1};
        func_tbl[3] = '{row0: 0, row1: 0, col0: 0, col1: 0, e00: 36, e01: 12, e10: 24, e11: 33};

        rst = 1'b1; load_in = 1'b0;
        mat1_row0 = '0; mat1_row1 = '0; mat2_col0 = '0; mat2_col1 = '0;

        apply_reset(2);
        check("reset c00", r00, 64'd0);
        check("reset c01", r01, 64'd0);
        check("reset c10", r10, 64'd0);
        check("reset c11", r11, 64'd0);
        check_carries("reset carries", 4'b0000);

        run_table("func", 4);
        check_carries("func carries", 4'b0000);

        // load_in high through reset release and 5 cycles: first post-reset cycle steps once.
        @(posedge clk); #1;
        rst = 1'b1; load_in = 1'b1;
        mat1_row0 = 3; mat2_col0 = 3; mat1_row1 = 0; mat2_col1 = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 load_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("edge single step c00", r00, 64'd9);

        apply_reset(2);
        do_step(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 2);
        check("ovf step1 c00", r00, 64'hFFFFFFFE00000001);
        check_carries("ovf step1 carries", 4'b0000);
        do_step(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 2);
        check("ovf step2 c00", r00, 64'hFFFFFFFC00000002);
        check_carries("ovf step2 carries", 4'b1000);

        apply_reset(2);
        do_step(32'h000000FF, 0, 32'h00000003, 0, 1);
        check("int8 c00", s00, 64'hFFFFFFFFFFFFFFFD);
        check("int8 carry00", {63'b0, sc00}, 64'd0);
        check("uint32 same step c00", r00, 64'd765);

        apply_reset(2);
        run_table("pre", 2);
        apply_reset(1);
        check("midreset c00", r00, 64'd0);
        check("midreset c01", r01, 64'd0);
        check("midreset c10", r10, 64'd0);
        check_carries("midreset carries", 4'b0000);
        run_table("rerun", 4);
        check_carries("rerun carries", 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
